// File: rtl/dram_line_master.sv
// rtl/dram_line_master.sv - whole-line read/write initiator for a single-port 1-cycle-latency DRAM port
module dram_line_master #(
  parameter int DATA  = 32,
  parameter int ADDR  = 28,
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR-1:0]       req_addr,
  input  logic [DATA*BEATS-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_wr,
  output logic [DATA*BEATS-1:0] resp_data,
  output logic                  dram_wr,
  output logic [ADDR-1:0]       dram_addr,
  output logic [DATA-1:0]       dram_din,
  input  logic [DATA-1:0]       dram_dout
);

  localparam int LB = $clog2(BEATS);
  localparam logic [LB-1:0] LAST = LB'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RTAIL, RESP} state_t;

  state_t                state;
  logic [LB-1:0]         beat;
  logic [LB-1:0]         beat_nxt;
  logic [LB-1:0]         beat_prv;
  logic [DATA*BEATS-1:0] wline;
  logic                  unused_addr_bits;

  // Line-offset bits of the request address are dropped: every access is line aligned.
  assign unused_addr_bits = ^req_addr[LB-1:0];

  assign req_ready = (state == IDLE);
  assign beat_nxt  = beat + 1'b1;
  assign beat_prv  = beat - 1'b1;

  // Line sequencer: one DRAM beat per cycle, then hold the response until the client takes it.
  // Beat addresses are formed by replacing only the low LB bits, so a line never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      wline      <= '0;
      dram_wr    <= 1'b0;
      dram_addr  <= '0;
      dram_din   <= '0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wline     <= req_data;
            beat      <= '0;
            dram_addr <= {req_addr[ADDR-1:LB], {LB{1'b0}}};
            dram_wr   <= req_wr;
            dram_din  <= req_data[DATA-1:0];
            state     <= req_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (beat != LAST) begin
            beat      <= beat_nxt;
            dram_addr <= {dram_addr[ADDR-1:LB], beat_nxt};
            dram_din  <= wline[beat_nxt*DATA +: DATA];
          end else begin
            dram_wr    <= 1'b0;
            resp_wr    <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        READ: begin
          // Data for the previous beat's address arrives one cycle late.
          if (beat != '0) begin
            resp_data[beat_prv*DATA +: DATA] <= dram_dout;
          end
          if (beat != LAST) begin
            beat      <= beat_nxt;
            dram_addr <= {dram_addr[ADDR-1:LB], beat_nxt};
          end else begin
            state <= RTAIL;
          end
        end
        RTAIL: begin
          resp_data[LAST*DATA +: DATA] <= dram_dout;
          resp_wr    <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_line_master.sv
// tb/tb_dram_line_master.sv - directed and mixed checks of dram_line_master against a DRAM and reference memory model
module tb_dram_line_master;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [7:0]   req_addr;
  logic [127:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_wr;
  logic [127:0] resp_data;
  logic         dram_wr;
  logic [7:0]   dram_addr;
  logic [31:0]  dram_din;
  logic [31:0]  dram_dout;

  logic         pre_en;
  logic [7:0]   pre_addr;
  logic [31:0]  pre_data;

  logic [31:0]  mem     [256];
  logic [31:0]  ref_mem [256];

  int total;
  int bad;

  dram_line_master #(.DATA(32), .ADDR(8), .BEATS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_wr    (resp_wr),
    .resp_data  (resp_data),
    .dram_wr    (dram_wr),
    .dram_addr  (dram_addr),
    .dram_din   (dram_din),
    .dram_dout  (dram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: synchronous write, registered read (1-cycle latency), plus a bench preload port.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (dram_wr) mem[dram_addr] <= dram_din;
    dram_dout <= mem[dram_addr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    step();
    pre_en = 1'b0;
  endtask

  // One full line transaction with per-beat DRAM checks, latency, hold and handshake checks.
  task automatic line(input logic wr, input logic [7:0] addr, input logic [127:0] wd,
                      input int hold, input logic pend);
    logic [7:0]   base;
    logic [127:0] exp;
    base = addr & 8'hFC;
    chk("req_ready_idle", {127'b0, req_ready}, 128'd1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = wd;
    step();
    req_valid = 1'b0; req_wr = ~wr; req_addr = ~addr; req_data = ~wd;
    if (wr) for (int k = 0; k < 4; k++) ref_mem[base + k] = wd[k*32 +: 32];
    exp = '0;
    for (int k = 0; k < 4; k++) exp[k*32 +: 32] = ref_mem[base + k];
    for (int k = 0; k < 4; k++) begin
      chk("beat_addr", {120'b0, dram_addr}, 128'(base + k));
      chk("beat_wr", {127'b0, dram_wr}, {127'b0, wr});
      if (wr) chk("beat_din", {96'b0, dram_din}, {96'b0, wd[k*32 +: 32]});
      chk("req_ready_busy", {127'b0, req_ready}, 128'd0);
      chk("resp_early", {127'b0, resp_valid}, 128'd0);
      step();
    end
    if (!wr) begin
      chk("rtail_wr", {127'b0, dram_wr}, 128'd0);
      chk("rtail_resp", {127'b0, resp_valid}, 128'd0);
      step();
    end
    chk("resp_valid", {127'b0, resp_valid}, 128'd1);
    chk("resp_wr", {127'b0, resp_wr}, {127'b0, wr});
    chk("resp_dram_wr", {127'b0, dram_wr}, 128'd0);
    if (!wr) chk("resp_data", resp_data, exp);
    if (pend) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = base;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {127'b0, resp_valid}, 128'd1);
      chk("hold_wr", {127'b0, resp_wr}, {127'b0, wr});
      if (!wr) chk("hold_data", resp_data, exp);
      chk("hold_req_ready", {127'b0, req_ready}, 128'd0);
      chk("hold_no_access", {127'b0, dram_wr}, 128'd0);
      chk("hold_addr", {120'b0, dram_addr}, 128'(base + 3));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_drop", {127'b0, resp_valid}, 128'd0);
    chk("req_ready_back", {127'b0, req_ready}, 128'd1);
  endtask

  initial begin
    logic [127:0] rd;
    total = 0; bad = 0;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    #1;
    chk("rst_req_ready", {127'b0, req_ready}, 128'd1);
    chk("rst_resp_valid", {127'b0, resp_valid}, 128'd0);
    chk("rst_dram_wr", {127'b0, dram_wr}, 128'd0);
    chk("rst_dram_addr", {120'b0, dram_addr}, 128'd0);
    chk("rst_resp_data", resp_data, 128'd0);
    step(); step();
    reset = 1'b0;

    // Zero the regions used so reads compare against known contents.
    for (int i = 0; i < 16; i++) preload(8'h20 + 8'(i), 32'h0);
    for (int i = 0; i < 4; i++) preload(8'h10 + 8'(i), 32'h0);
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 32'hE0 + 32'(i));

    // Abort a write at beat 2 with reset.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h41;
    req_data = {32'h14, 32'h13, 32'h12, 32'h11};
    step();
    req_valid = 1'b0;
    step(); step();
    chk("abort_addr", {120'b0, dram_addr}, 128'h42);
    chk("abort_wr_pre", {127'b0, dram_wr}, 128'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_wr_now", {127'b0, dram_wr}, 128'd0);
    step(); step();
    reset = 1'b0;
    chk("abort_req_ready", {127'b0, req_ready}, 128'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_resp", {127'b0, resp_valid}, 128'd0);
      step();
    end
    chk("abort_mem40", {96'b0, mem[8'h40]}, 128'h11);
    chk("abort_mem41", {96'b0, mem[8'h41]}, 128'h12);
    chk("abort_mem42", {96'b0, mem[8'h42]}, 128'hE2);
    chk("abort_mem43", {96'b0, mem[8'h43]}, 128'hE3);
    ref_mem[8'h40] = 32'h11;
    ref_mem[8'h41] = 32'h12;

    // Write then read the same line; read held off for 10 cycles with a pending request.
    line(1'b1, 8'h12, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 1'b0);
    chk("wr_mem13", {96'b0, mem[8'h13]}, 128'hD);
    line(1'b0, 8'h10, 128'h0, 10, 1'b1);
    line(1'b0, 8'h10, 128'h0, 0, 1'b0);
    rd = resp_data;
    chk("rd_line_const", rd, {32'hD, 32'hC, 32'hB, 32'hA});

    // Top-of-space line must not wrap.
    for (int i = 0; i < 4; i++) preload(8'hFC + 8'(i), 32'(i + 1));
    line(1'b0, 8'hFF, 128'h0, 1, 1'b0);
    chk("top_line", resp_data, {32'd4, 32'd3, 32'd2, 32'd1});
    line(1'b0, 8'h41, 128'h0, 0, 1'b0);
    chk("abort_line", resp_data, {32'hE3, 32'hE2, 32'h12, 32'h11});

    // Mixed traffic over four lines with random response back-pressure.
    for (int n = 0; n < 20; n++) begin
      line(1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
